// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM encoding, grant owner, default widths.
// Pure declarations; no latency or flow-control behaviour of its own.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  function automatic owner_t state_owner(arb_state_t s);
    case (s)
      GNT_IF:  return OWN_IF;
      GNT_DM:  return OWN_DM;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter: clr wins over inc, sat flags the limit; 1-cycle update.
// No handshake; the owner decides when to increment or clear.
module arb_starve_cnt #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// IF/MEM arbiter for the single-port memory: data has priority, starvation counter forces fetch; request-to-ack >= 2 cycles.
// Requesters hold req until a one-cycle ack; memory side holds mem_req until mem_ready.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t state;
  logic       if_act, dm_act;
  logic       grant_if, grant_dm;
  logic       starve_sat;

  // A requester acked this cycle still holds req; masking it stops an immediate re-grant.
  assign if_act   = if_req & ~if_ack;
  assign dm_act   = dm_req & ~dm_ack;
  assign if_stall = if_act;
  assign dm_stall = dm_act;

  assign grant_if = (state == IDLE) && if_act && (!dm_act || starve_sat);
  assign grant_dm = (state == IDLE) && dm_act && !grant_if;

  arb_starve_cnt #(
    .W   (STARVE_CNT_W),
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .rstn (rstn),
    .inc  (grant_dm && if_act),
    .clr  (grant_if),
    .sat  (starve_sat)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            state     <= GNT_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end else if (grant_dm) begin
            state     <= GNT_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end
        end
        GNT_IF, GNT_DM: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state_owner(state) == OWN_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_ack <= 1'b1;
              if (!mem_we) dm_rdata <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
